// File: rtl/rib_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : rib_dma_pkg
//  Purpose : Shared definitions for the RIB DMA copy engine.
//            - Bus widths (memory data and address).
//            - Register byte offsets and CTRL/STATUS bit indices.
//            - FSM state encoding.
//            - Word-alignment helper.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package rib_dma_pkg;

    localparam int MEM_W  = 32;
    localparam int ADDR_W = 32;

    // Register byte offsets within the slave window
    localparam logic [7:0] DMA_CTRL   = 8'h00;
    localparam logic [7:0] DMA_STATUS = 8'h04;
    localparam logic [7:0] DMA_SRC    = 8'h08;
    localparam logic [7:0] DMA_DST    = 8'h0C;
    localparam logic [7:0] DMA_LEN    = 8'h10;
    localparam logic [7:0] DMA_CNT    = 8'h14;

    // CTRL bits
    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ABORT  = 2;

    // STATUS bits
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;

    localparam logic [ADDR_W-1:0] WORD_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } dma_state_e;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rib_dma.sv
`default_nettype none
// ============================================================================
//  Module  : rib_dma
//  Purpose : Word-granular memory-to-memory copy engine. Programmed through
//            a RIB slave register port; streams LEN words SRC->DST as
//            alternating read/write beats on its RIB master port.
//  Ports   : clk, rst (async, active-high)
//            slave : we_i, addr_i, data_i, data_o (combinational read)
//            master: m_req_o, m_we_o, m_addr_o, m_data_o, m_data_i, m_gnt_i
//            int_o : level interrupt = STATUS.done & CTRL.irq_en
//  Rev     : 1.0  initial release
// ============================================================================
module rib_dma
    import rib_dma_pkg::*;
#(
    parameter int LEN_W  = 16,
    parameter int REG_AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [MEM_W-1:0]  data_i,
    output logic [MEM_W-1:0]  data_o,
    output logic              m_req_o,
    output logic              m_we_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [MEM_W-1:0]  m_data_o,
    input  logic [MEM_W-1:0]  m_data_i,
    input  logic              m_gnt_i,
    output logic              int_o
);

    dma_state_e        state_q;
    logic              irq_en_q, done_q, aborted_q;
    logic [ADDR_W-1:0] src_q, dst_q, cur_src_q, cur_dst_q;
    logic [LEN_W-1:0]  len_q, cnt_q;
    logic              m_req_q, m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [MEM_W-1:0]  m_data_q;   // doubles as the read->write word buffer

    // Slave address decode
    logic [REG_AW-1:0] w_off;
    logic w_sel_ctrl, w_sel_stat, w_sel_src, w_sel_dst, w_sel_len, w_sel_cnt;
    logic w_busy, w_start, w_abort, w_beat, w_last;
    logic w_unused_addr;

    assign w_off      = addr_i[REG_AW-1:0];
    assign w_sel_ctrl = (w_off == REG_AW'(DMA_CTRL));
    assign w_sel_stat = (w_off == REG_AW'(DMA_STATUS));
    assign w_sel_src  = (w_off == REG_AW'(DMA_SRC));
    assign w_sel_dst  = (w_off == REG_AW'(DMA_DST));
    assign w_sel_len  = (w_off == REG_AW'(DMA_LEN));
    assign w_sel_cnt  = (w_off == REG_AW'(DMA_CNT));
    assign w_unused_addr = ^addr_i[ADDR_W-1:REG_AW];

    assign w_busy  = (state_q != ST_IDLE);
    assign w_start = we_i & w_sel_ctrl & data_i[CTRL_START] & ~w_busy;
    assign w_abort = we_i & w_sel_ctrl & data_i[CTRL_ABORT] & w_busy;
    assign w_beat  = m_req_q & m_gnt_i;
    assign w_last  = (cnt_q == LEN_W'(1));

    assign m_req_o  = m_req_q;
    assign m_we_o   = m_we_q;
    assign m_addr_o = m_addr_q;
    assign m_data_o = m_data_q;
    assign int_o    = done_q & irq_en_q;

    // Register read mux; start/abort are write-only strobes and read as 0
    always_comb begin
        data_o = '0;
        if (w_sel_ctrl) begin
            data_o[CTRL_IRQ_EN] = irq_en_q;
        end else if (w_sel_stat) begin
            data_o[STAT_BUSY]    = w_busy;
            data_o[STAT_DONE]    = done_q;
            data_o[STAT_ABORTED] = aborted_q;
        end else if (w_sel_src) begin
            data_o = src_q;
        end else if (w_sel_dst) begin
            data_o = dst_q;
        end else if (w_sel_len) begin
            data_o = MEM_W'(len_q);
        end else if (w_sel_cnt) begin
            data_o = MEM_W'(cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_data_q  <= '0;
        end else begin
            if (we_i && w_sel_ctrl) begin
                irq_en_q <= data_i[CTRL_IRQ_EN];
            end
            // W1C comes first so a same-cycle set further down wins
            if (we_i && w_sel_stat) begin
                if (data_i[STAT_DONE])    done_q    <= 1'b0;
                if (data_i[STAT_ABORTED]) aborted_q <= 1'b0;
            end
            // Transfer parameters are frozen while a copy is running
            if (we_i && !w_busy) begin
                if (w_sel_src) src_q <= word_align(data_i);
                if (w_sel_dst) dst_q <= word_align(data_i);
                if (w_sel_len) len_q <= data_i[LEN_W-1:0];
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_start) begin
                        if (len_q != '0) begin
                            cur_src_q <= src_q;
                            cur_dst_q <= dst_q;
                            cnt_q     <= len_q;
                            state_q   <= ST_RD;
                            m_req_q   <= 1'b1;
                            m_we_q    <= 1'b0;
                            m_addr_q  <= src_q;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (w_beat) begin
                        m_data_q  <= m_data_i;
                        cur_src_q <= cur_src_q + WORD_STEP;
                        state_q   <= ST_WR;
                        m_we_q    <= 1'b1;
                        m_addr_q  <= cur_dst_q;
                    end
                    if (w_abort) begin
                        state_q   <= ST_IDLE;
                        m_req_q   <= 1'b0;
                        m_we_q    <= 1'b0;
                        aborted_q <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (w_beat) begin
                        cur_dst_q <= cur_dst_q + WORD_STEP;
                        cnt_q     <= cnt_q - LEN_W'(1);
                        if (w_last) begin
                            state_q <= ST_IDLE;
                            m_req_q <= 1'b0;
                            m_we_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= ST_RD;
                            m_we_q   <= 1'b0;
                            m_addr_q <= cur_src_q;
                        end
                    end
                    // An abort racing the final write is moot: the copy completed
                    if (w_abort && !(w_beat && w_last)) begin
                        state_q   <= ST_IDLE;
                        m_req_q   <= 1'b0;
                        m_we_q    <= 1'b0;
                        aborted_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    m_req_q <= 1'b0;
                    m_we_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rib_dma.sv
`default_nettype none
// ============================================================================
//  Module  : tb_rib_dma
//  Purpose : Self-checking bench for rib_dma: register table vectors plus
//            directed copy, stall, zero-length, wrap, abort, reset and
//            done set/clear race sequences.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_rib_dma;

    logic        clk, rst;
    logic        we_i;
    logic [31:0] addr_i, data_i, data_o;
    logic        m_req_o, m_we_o;
    logic [31:0] m_addr_o, m_data_o, m_data_i;
    logic        m_gnt_i;
    logic        int_o;

    int n_checks = 0;
    int n_err    = 0;
    int gnt_mode = 0;   // 0: always grant, 1: grant one cycle in three, 2: never
    int cyc      = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t       beats[$];
    int          req_cnt  = 0;
    int          stab_err = 0;
    logic        hold_q   = 1'b0;
    logic [65:0] hold_val = '0;

    rib_dma dut (
        .clk      (clk),
        .rst      (rst),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .data_o   (data_o),
        .m_req_o  (m_req_o),
        .m_we_o   (m_we_o),
        .m_addr_o (m_addr_o),
        .m_data_o (m_data_o),
        .m_data_i (m_data_i),
        .m_gnt_i  (m_gnt_i),
        .int_o    (int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source memory content is a fixed function of the address
    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    assign m_data_i = pat(m_addr_o);
    assign m_gnt_i  = (gnt_mode == 0) ? 1'b1 :
                      (gnt_mode == 1) ? (cyc % 3 == 2) : 1'b0;

    // Bus monitor: logs granted beats, counts requests, checks hold-while-stalled
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_req_o) req_cnt <= req_cnt + 1;
        if (m_req_o && m_gnt_i)
            beats.push_back('{we: m_we_o, addr: m_addr_o, data: (m_we_o ? m_data_o : m_data_i)});
        if (hold_q && ({m_req_o, m_we_o, m_addr_o, m_data_o} !== hold_val))
            stab_err <= stab_err + 1;
        hold_q   <= m_req_o && !m_gnt_i;
        hold_val <= {m_req_o, m_we_o, m_addr_o, m_data_o};
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All tasks are entered right after a falling edge
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we_i = 1'b1; addr_i = a; data_i = d;
        @(negedge clk);
        we_i = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        we_i = 1'b0; addr_i = a;
        #1;
        d = data_o;
    endtask

    function automatic int count_wr(input int b0);
        int c = 0;
        for (int i = b0; i < beats.size(); i++) if (beats[i].we) c++;
        return c;
    endfunction

    task automatic check_copy(input string tag, input int b0, input logic [31:0] src,
                              input logic [31:0] dst, input int n);
        logic [31:0] a;
        check({tag, "_nbeats"}, beats.size() - b0, 2 * n);
        if (beats.size() - b0 == 2 * n) begin
            for (int k = 0; k < n; k++) begin
                a = src + 32'(4 * k);
                check({tag, "_rd_beat"}, {31'b0, beats[b0 + 2*k]},     {31'b0, 1'b0, a, pat(a)});
                check({tag, "_wr_beat"}, {31'b0, beats[b0 + 2*k + 1]},
                      {31'b0, 1'b1, dst + 32'(4 * k), pat(a)});
            end
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        logic [31:0] s;
        int k = 0;
        rd(32'h04, s);
        while (!s[1] && k < limit) begin
            @(negedge clk);
            rd(32'h04, s);
            k++;
        end
        check({tag, "_done_reached"}, s[1], 1);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[13];
    logic [31:0] r;
    int          b0, q0, s0, k;

    initial begin
        vecs[0]  = '{1'b0, 32'h00, 32'h0,         32'h0};          // CTRL reset
        vecs[1]  = '{1'b0, 32'h04, 32'h0,         32'h0};          // STATUS reset
        vecs[2]  = '{1'b0, 32'h08, 32'h0,         32'h0};          // SRC reset
        vecs[3]  = '{1'b0, 32'h14, 32'h0,         32'h0};          // CNT reset
        vecs[4]  = '{1'b1, 32'h08, 32'h1234_5677, 32'h1234_5674};  // SRC low bits forced 0
        vecs[5]  = '{1'b1, 32'h0C, 32'hABCD_EF03, 32'hABCD_EF00};  // DST low bits forced 0
        vecs[6]  = '{1'b1, 32'h10, 32'hFFFF_0005, 32'h0000_0005};  // LEN truncated to 16 bits
        vecs[7]  = '{1'b1, 32'h00, 32'h0000_0002, 32'h0000_0002};  // irq_en RW
        vecs[8]  = '{1'b1, 32'h00, 32'h0000_0000, 32'h0000_0000};
        vecs[9]  = '{1'b0, 32'h18, 32'h0,         32'h0};          // unmapped
        vecs[10] = '{1'b1, 32'h108, 32'h0000_0040, 32'h0000_0040}; // upper address bits ignored
        vecs[11] = '{1'b1, 32'h14, 32'h0000_0055, 32'h0};          // CNT is read-only
        vecs[12] = '{1'b1, 32'h04, 32'h0000_0007, 32'h0};          // W1C with nothing set

        rst = 1'b1; we_i = 1'b0; addr_i = '0; data_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_outputs", {m_req_o, m_we_o, m_addr_o, m_data_o, int_o}, '0);
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, r);
            check($sformatf("reg_vec%0d", i), r, vecs[i].exp);
            @(negedge clk);
        end

        // ---- Basic copy, full grant, irq enabled ----
        gnt_mode = 0;
        wr(32'h08, 32'h1000_0000);
        wr(32'h0C, 32'h1000_0100);
        wr(32'h10, 32'd4);
        b0 = beats.size();
        wr(32'h00, 32'h3);                     // start + irq_en
        check("start_latency_req", m_req_o, 1);
        rd(32'h04, r);
        check("copy_busy_first", r, 32'h1);
        repeat (7) @(negedge clk);
        rd(32'h04, r);
        check("copy_busy_last", r, 32'h1);
        @(negedge clk);
        rd(32'h04, r);
        check("copy_done_status", r, 32'h2);
        check("copy_int_on", int_o, 1);
        rd(32'h14, r);
        check("copy_cnt_zero", r, 0);
        check_copy("copy", b0, 32'h1000_0000, 32'h1000_0100, 4);
        wr(32'h00, 32'h0);
        check("irq_disabled_int_off", int_o, 0);
        wr(32'h04, 32'h2);
        rd(32'h04, r);
        check("done_w1c", r, 0);

        // ---- Same copy under stalled grant ----
        @(negedge clk);
        gnt_mode = 1;
        b0 = beats.size();
        s0 = stab_err;
        wr(32'h00, 32'h1);
        wait_done("stall", 200);
        check("stall_outputs_stable", stab_err - s0, 0);
        check_copy("stall", b0, 32'h1000_0000, 32'h1000_0100, 4);
        gnt_mode = 0;
        wr(32'h04, 32'h2);

        // ---- Zero-length start ----
        wr(32'h10, 32'd0);
        q0 = req_cnt;
        wr(32'h00, 32'h1);
        rd(32'h04, r);
        check("len0_done_next_cycle", r, 32'h2);
        repeat (3) @(negedge clk);
        check("len0_no_request", req_cnt - q0, 0);
        wr(32'h04, 32'h2);

        // ---- Address wrap ----
        wr(32'h08, 32'hFFFF_FFF8);
        wr(32'h0C, 32'h2000_0000);
        wr(32'h10, 32'd3);
        b0 = beats.size();
        wr(32'h00, 32'h1);
        wait_done("wrap", 20);
        check_copy("wrap", b0, 32'hFFFF_FFF8, 32'h2000_0000, 3);
        wr(32'h04, 32'h2);

        // ---- Abort after third write; SRC write while busy ignored ----
        wr(32'h08, 32'h3000_0000);
        wr(32'h0C, 32'h4000_0000);
        wr(32'h10, 32'd16);
        b0 = beats.size();
        wr(32'h00, 32'h1);
        wr(32'h08, 32'h5555_0000);
        k = 0;
        while (count_wr(b0) < 3 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("abort_three_writes", count_wr(b0), 3);
        gnt_mode = 2;
        wr(32'h00, 32'h4);
        rd(32'h04, r);
        check("abort_status", r, 32'h4);
        rd(32'h14, r);
        check("abort_cnt", r, 32'd13);
        rd(32'h08, r);
        check("busy_src_write_ignored", r, 32'h3000_0000);
        gnt_mode = 0;
        repeat (4) @(negedge clk);
        check("abort_no_more_beats", beats.size() - b0, 6);
        check("abort_req_low", m_req_o, 0);
        wr(32'h04, 32'h4);

        // ---- Async reset in the middle of a write beat ----
        wr(32'h08, 32'h1000_0000);
        wr(32'h0C, 32'h1000_0100);
        wr(32'h10, 32'd4);
        wr(32'h00, 32'h1);
        @(negedge clk);
        #2;
        check("pre_reset_in_wr", {m_req_o, m_we_o}, 2'b11);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {m_req_o, m_we_o, m_addr_o, m_data_o, int_o}, '0);
        @(negedge clk);
        rst = 1'b0;
        rd(32'h04, r);
        check("reset_status_cleared", r, 0);
        rd(32'h10, r);
        check("reset_len_cleared", r, 0);

        // ---- done set and W1C of done in the same cycle: set wins ----
        @(negedge clk);
        wr(32'h08, 32'h5000_0000);
        wr(32'h0C, 32'h6000_0000);
        wr(32'h10, 32'd1);
        b0 = beats.size();
        wr(32'h00, 32'h1);
        @(negedge clk);
        wr(32'h04, 32'h2);                     // lands on the final write edge
        rd(32'h04, r);
        check("done_set_beats_w1c", r, 32'h2);
        wr(32'h04, 32'h2);
        rd(32'h04, r);
        check("done_clear_after", r, 0);
        check_copy("race", b0, 32'h5000_0000, 32'h6000_0000, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
